// File: rtl/lcd_write_arbiter_pkg.sv
// lcd_write_arbiter_pkg: shared state encoding and LCD field widths for the write arbiter.
package lcd_write_arbiter_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE_GAP} state_e;
    localparam int ROW_W  = 2;
    localparam int COL_W  = 4;
    localparam int CHAR_W = 8;
endpackage

// File: rtl/lcd_write_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector, first valid index after last_i (mod N).
module rr_pick #(
    parameter int N = 2
) (
    input  logic [N-1:0] valid_i,
    input  logic [1:0]   last_i,
    output logic         found_o,
    output logic [1:0]   idx_o
);
    logic [N-1:0] sh;
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        sh      = '0;
        // Scan farthest-first so the nearest candidate overwrites last.
        for (int k = N; k >= 1; k--) begin
            sh = valid_i >> ((int'(last_i) + k) % N);
            if (sh[0]) begin
                found_o = 1'b1;
                idx_o   = 2'((int'(last_i) + k) % N);
            end
        end
    end
endmodule

// File: rtl/lcd_write_arbiter.sv
// lcd_write_arbiter: round-robin sharing of the LCD character-write port with burst hold
// and a done-watchdog that abandons writes the controller never completes.
module lcd_write_arbiter
    import lcd_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ             = 2,
    parameter int CLK_HZ              = 100_000_000,
    parameter int DONE_TIMEOUT_CYCLES = CLK_HZ / 100
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    rq_valid,
    input  logic [NUM_REQ-1:0]    rq_hold,
    input  logic [2*NUM_REQ-1:0]  rq_row,
    input  logic [4*NUM_REQ-1:0]  rq_col,
    input  logic [8*NUM_REQ-1:0]  rq_char,
    output logic [NUM_REQ-1:0]    rq_ack,
    output logic [NUM_REQ-1:0]    rq_done,
    output logic                  rq_err,
    output logic                  lcd_req,
    output logic [ROW_W-1:0]      lcd_row,
    output logic [COL_W-1:0]      lcd_col,
    output logic [CHAR_W-1:0]     lcd_char,
    input  logic                  lcd_busy,
    input  logic                  lcd_done,
    output logic [1:0]            owner
);
    state_e              state_q, state_d;
    logic [1:0]          last_q, last_d, owner_q, owner_d, win, pick_idx;
    logic                lock_q, lock_d, pick_found, lock_hit, hold_own, timeout;
    logic [31:0]         wd_q, wd_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d, own_oh, win_oh;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [CHAR_W-1:0]   char_q, char_d;

    rr_pick #(.N(NUM_REQ)) u_pick (
        .valid_i (rq_valid),
        .last_i  (last_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    assign own_oh   = NUM_REQ'(1) << owner_q;
    assign lock_hit = lock_q & |(rq_valid & (NUM_REQ'(1) << last_q));
    assign win      = lock_hit ? last_q : pick_idx;
    assign win_oh   = NUM_REQ'(1) << win;
    assign hold_own = |(rq_hold & own_oh);
    assign timeout  = wd_q == 32'(DONE_TIMEOUT_CYCLES - 1);

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        lock_d  = lock_q;
        wd_d    = wd_q;
        ack_d   = '0;
        row_d   = row_q;
        col_d   = col_q;
        char_d  = char_q;
        lcd_req = 1'b0;
        rq_done = '0;
        rq_err  = 1'b0;
        case (state_q)
            IDLE: if (!lcd_busy && pick_found) begin
                lock_d  = lock_hit;
                owner_d = win;
                ack_d   = win_oh;
                row_d   = ROW_W'(rq_row >> (ROW_W * win));
                col_d   = COL_W'(rq_col >> (COL_W * win));
                char_d  = CHAR_W'(rq_char >> (CHAR_W * win));
                state_d = ISSUE;
            end
            ISSUE: begin
                lcd_req = 1'b1;
                wd_d    = '0;
                state_d = WAIT;
            end
            WAIT: begin
                wd_d = wd_q + 32'd1;
                // A real completion beats a coinciding timeout.
                if (lcd_done || timeout) begin
                    rq_done = own_oh;
                    rq_err  = !lcd_done;
                    last_d  = owner_q;
                    lock_d  = lcd_done & hold_own;
                    state_d = DONE_GAP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 2'(NUM_REQ - 1);
            owner_q <= '0;
            lock_q  <= 1'b0;
            wd_q    <= '0;
            ack_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            char_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            lock_q  <= lock_d;
            wd_q    <= wd_d;
            ack_q   <= ack_d;
            row_q   <= row_d;
            col_q   <= col_d;
            char_q  <= char_d;
        end
    end

    assign rq_ack   = ack_q;
    assign owner    = owner_q;
    assign lcd_row  = row_q;
    assign lcd_col  = col_q;
    assign lcd_char = char_q;
endmodule

// File: tb/tb_lcd_write_arbiter.sv
// tb_lcd_write_arbiter: scoreboard bench with a behavioural LCD controller and two requesters.
module tb_lcd_write_arbiter;
    localparam int TMO = 50;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [1:0]  rq_valid = '0, rq_hold = '0, rq_ack, rq_done, owner;
    logic [3:0]  rq_row = '0;
    logic [7:0]  rq_col = '0;
    logic [15:0] rq_char = '0;
    logic        rq_err, lcd_req, lcd_busy = 1'b0, lcd_done = 1'b0;
    logic [1:0]  lcd_row;
    logic [3:0]  lcd_col;
    logic [7:0]  lcd_char;

    lcd_write_arbiter #(.NUM_REQ(2), .CLK_HZ(100_000_000), .DONE_TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .rq_valid(rq_valid), .rq_hold(rq_hold),
        .rq_row(rq_row), .rq_col(rq_col), .rq_char(rq_char),
        .rq_ack(rq_ack), .rq_done(rq_done), .rq_err(rq_err),
        .lcd_req(lcd_req), .lcd_row(lcd_row), .lcd_col(lcd_col), .lcd_char(lcd_char),
        .lcd_busy(lcd_busy), .lcd_done(lcd_done), .owner(owner)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         who;
        logic [1:0] row;
        logic [3:0] col;
        logic [7:0] ch;
        bit         err;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       cur;
    bit         inflight, force_busy;
    int         n_cmp, n_bad, cyc, req_cyc, n_acks, m_cnt, a0;
    int         rem[2], sq[2], lat[2];
    bit         burst[2];
    logic [1:0] brow[2];
    logic [3:0] bcol[2];
    logic [7:0] bch[2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic load(input int i, input int n, input logic [1:0] r, input logic [3:0] c,
                        input logic [7:0] ch, input bit b, input int l);
        rem[i] = n; sq[i] = 0; brow[i] = r; bcol[i] = c; bch[i] = ch; burst[i] = b; lat[i] = l;
    endtask

    task automatic expect_w(input int i, input int k, input bit e);
        exp_t x;
        x.who = i; x.row = brow[i]; x.col = bcol[i] + 4'(k); x.ch = bch[i] + 8'(k); x.err = e;
        exp_q.push_back(x);
    endtask

    // One cycle: drive requesters and controller model at negedge, then check outputs.
    task automatic step();
        @(negedge clk);
        lcd_done = 1'b0;
        if (m_cnt > 0) begin
            m_cnt--;
            lcd_done = (m_cnt == 0);
        end
        lcd_busy = force_busy || m_cnt > 0;
        for (int i = 0; i < 2; i++) begin
            rq_valid[i]       = rem[i] > 0;
            rq_hold[i]        = burst[i] && rem[i] > 0;
            rq_row[2*i +: 2]  = brow[i];
            rq_col[4*i +: 4]  = bcol[i] + 4'(sq[i]);
            rq_char[8*i +: 8] = bch[i] + 8'(sq[i]);
        end
        #1;
        cyc++;
        if (lcd_req || rq_ack != 0) chk("req_with_ack", 32'(lcd_req), 32'(|rq_ack));
        if (rq_ack != 0) begin
            n_acks++;
            chk("ack_overlap", 32'(inflight), 0);
            if (exp_q.size() == 0) chk("ack_unexpected", 32'(rq_ack), 0);
            else begin
                cur = exp_q.pop_front();
                inflight = 1'b1;
                req_cyc = cyc;
                chk("ack_who", 32'(rq_ack), 32'(1) << cur.who);
                chk("owner", 32'(owner), cur.who);
                chk("lcd_row", 32'(lcd_row), 32'(cur.row));
                chk("lcd_col", 32'(lcd_col), 32'(cur.col));
                chk("lcd_char", 32'(lcd_char), 32'(cur.ch));
                if (lat[cur.who] > 0) m_cnt = lat[cur.who];
            end
            for (int i = 0; i < 2; i++) if (rq_ack[i] && rem[i] > 0) begin
                rem[i]--;
                sq[i]++;
            end
        end
        if (rq_done != 0) begin
            chk("done_inflight", 32'(inflight), 1);
            if (inflight) begin
                chk("done_who", 32'(rq_done), 32'(1) << cur.who);
                chk("done_err", 32'(rq_err), 32'(cur.err));
                chk("done_latency", cyc - req_cyc, cur.err ? TMO : lat[cur.who]);
            end
            inflight = 1'b0;
        end else if (rq_err) chk("err_without_done", 32'(rq_err), 0);
    endtask

    task automatic run_until_idle(input string tag, input int max);
        int n = 0;
        do begin
            step();
            n++;
        end while (!(exp_q.size() == 0 && !inflight && m_cnt == 0) && n < max);
        chk({tag, "_drained"}, 32'(exp_q.size() == 0 && !inflight), 1);
        repeat (2) step();
    endtask

    task automatic wait_ack(input string tag, input int i, input int max);
        int n = 0;
        do begin
            step();
            n++;
        end while (!rq_ack[i] && n < max);
        chk({tag, "_ack"}, 32'(rq_ack[i]), 1);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) load(i, 0, '0, '0, '0, 1'b0, 0);
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ack", 32'(rq_ack), 0);
        chk("rst_done", 32'({rq_done, rq_err, lcd_req}), 0);
        chk("rst_fields", 32'({lcd_row, lcd_col, lcd_char, owner}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) step();

        // single write from requester 0
        load(0, 1, 2'd1, 4'd3, 8'h41, 1'b0, 40);
        expect_w(0, 0, 1'b0);
        run_until_idle("single", 200);

        // busy blocks arbitration; ack follows the cycle after busy drops
        force_busy = 1'b1;
        load(1, 1, 2'd2, 4'd7, 8'h52, 1'b0, 5);
        expect_w(1, 0, 1'b0);
        a0 = n_acks;
        repeat (10) step();
        chk("busy_blocks_ack", n_acks - a0, 0);
        force_busy = 1'b0;
        step();
        chk("busy_drop_same", 32'(rq_ack), 0);
        step();
        chk("busy_drop_next", 32'(rq_ack), 32'b10);
        run_until_idle("busy", 100);

        // both continuously valid: rotation 0,1,0,1
        load(0, 2, 2'd0, 4'd1, 8'h30, 1'b0, 5);
        load(1, 2, 2'd3, 4'd8, 8'h60, 1'b0, 5);
        expect_w(0, 0, 1'b0); expect_w(1, 0, 1'b0); expect_w(0, 1, 1'b0); expect_w(1, 1, 1'b0);
        run_until_idle("rotate", 300);

        // requester 0 never completes: watchdog abandon, then requester 1 served
        load(0, 1, 2'd1, 4'd2, 8'h70, 1'b0, 0);
        load(1, 1, 2'd2, 4'd9, 8'h71, 1'b0, 6);
        expect_w(0, 0, 1'b1); expect_w(1, 0, 1'b0);
        run_until_idle("timeout", 300);

        // burst hold: 1,1,1 then 0
        load(1, 3, 2'd3, 4'd4, 8'h80, 1'b1, 4);
        load(0, 0, 2'd0, 4'd6, 8'h90, 1'b0, 4);
        expect_w(1, 0, 1'b0); expect_w(1, 1, 1'b0); expect_w(1, 2, 1'b0); expect_w(0, 0, 1'b0);
        wait_ack("burst", 1, 20);
        rem[0] = 1;
        run_until_idle("burst", 300);

        // reset while waiting for done
        load(1, 1, 2'd2, 4'd5, 8'h55, 1'b0, 40);
        expect_w(1, 0, 1'b0);
        wait_ack("abort", 1, 20);
        repeat (5) step();
        @(negedge clk);
        rst_n = 1'b0;
        m_cnt = 0; lcd_busy = 1'b0; lcd_done = 1'b0;
        #1;
        chk("abort_ack", 32'(rq_ack), 0);
        chk("abort_done", 32'({rq_done, rq_err, lcd_req}), 0);
        chk("abort_fields", 32'({lcd_row, lcd_col, lcd_char, owner}), 0);
        exp_q.delete();
        inflight = 1'b0;
        for (int i = 0; i < 2; i++) load(i, 0, '0, '0, '0, 1'b0, 0);
        repeat (3) step();
        @(negedge clk);
        rst_n = 1'b1;
        load(0, 1, 2'd1, 4'd10, 8'hA0, 1'b0, 5);
        load(1, 1, 2'd3, 4'd11, 8'hB0, 1'b0, 5);
        expect_w(0, 0, 1'b0); expect_w(1, 0, 1'b0);
        run_until_idle("post_reset", 200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
